// File: rtl/bargraph_led_driver.sv
// LED bank driver behind the bar-graph decoder: PWM dimming, peak-hold marker and error blink.
// Optional macro PEAK_HOLD_EN enables the decaying peak marker; when undefined Peak_out is tied low.
module bargraph_led_driver #(
  parameter int unsigned PRESCALE_DIV = 1000,
  parameter int unsigned PWM_BITS     = 3,
  parameter int unsigned HOLD_TICKS   = 50,
  parameter int unsigned BLINK_TICKS  = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          BGraph_in,
  input  logic                Err_in,
  input  logic [PWM_BITS-1:0] Bright_in,
  output logic [7:0]          Led_out,
  output logic [7:0]          Peak_out,
  output logic                ErrLed_out
);

  localparam int unsigned PRE_W   = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);

  if (PRESCALE_DIV < 2 || BLINK_TICKS < 1 || HOLD_TICKS < 1 || PWM_BITS < 1) begin : g_bad_params
    $error("bargraph_led_driver: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    ERR_ON  = 2'd1,
    ERR_OFF = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PRE_W-1:0]     presc;
  logic                 tick;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic                 pwm_on;
  logic [7:0]           bar_q;
  logic                 err_q;
  logic [BLINK_W-1:0]   blink;
  logic [BLINK_W-1:0]   blink_nxt;
  logic [7:0]           peak_show;
  logic [7:0]           led_nxt;
  logic                 err_led_nxt;

  // Timing tick prescaler
  assign tick = (presc == PRE_W'(PRESCALE_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Free-running PWM counter; full-scale code forces the LEDs permanently on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign pwm_on = (&Bright_in) | (pwm_cnt < Bright_in);

  // Input stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_q <= '0;
      err_q <= 1'b0;
    end else begin
      bar_q <= BGraph_in;
      err_q <= Err_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
      blink <= '0;
    end else begin
      state <= state_nxt;
      blink <= blink_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    blink_nxt = blink;
    case (state)
      NORMAL: begin
        if (err_q) begin
          state_nxt = ERR_ON;
          blink_nxt = '0;
        end
      end
      ERR_ON, ERR_OFF: begin
        if (!err_q) begin
          state_nxt = NORMAL;
          blink_nxt = '0;
        end else if (tick) begin
          if (blink == BLINK_W'(BLINK_TICKS - 1)) begin
            blink_nxt = '0;
            state_nxt = (state == ERR_ON) ? ERR_OFF : ERR_ON;
          end else begin
            blink_nxt = blink + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = NORMAL;
        blink_nxt = '0;
      end
    endcase
  end

`ifdef PEAK_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  logic [3:0]        lvl;
  logic [3:0]        peak;
  logic [3:0]        peak_nxt;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_nxt;
  logic [7:0]        peak_oh_nxt;

  // Level is the top set segment; gaps below it do not matter
  always_comb begin
    lvl = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bar_q[i]) begin
        lvl = 4'(i + 1);
      end
    end
  end

  // Peak is forced to zero whenever the next state is an error state, so it
  // restarts from the live bar on the first NORMAL cycle after an error
  always_comb begin
    peak_nxt = peak;
    hold_nxt = hold;
    if (state_nxt != NORMAL) begin
      peak_nxt = '0;
      hold_nxt = '0;
    end else if (lvl >= peak) begin
      peak_nxt = lvl;
      hold_nxt = HOLD_W'(HOLD_TICKS);
    end else if (tick) begin
      if (hold != '0) begin
        hold_nxt = hold - 1'b1;
      end else if (peak != '0) begin
        peak_nxt = peak - 1'b1;
      end
    end
  end

  always_comb begin
    peak_oh_nxt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      peak_oh_nxt[i] = (peak_nxt == 4'(i + 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak     <= '0;
      hold     <= '0;
      Peak_out <= '0;
    end else begin
      peak     <= peak_nxt;
      hold     <= hold_nxt;
      Peak_out <= peak_oh_nxt;
    end
  end

  assign peak_show = Peak_out;
`else
  assign Peak_out  = '0;
  assign peak_show = '0;
`endif

  // Outputs follow the upcoming state so error entry/exit shows with the same
  // two-clock latency as the bar path
  always_comb begin
    led_nxt     = '0;
    err_led_nxt = 1'b0;
    case (state_nxt)
      NORMAL: begin
        led_nxt = (bar_q | peak_show) & {8{pwm_on}};
      end
      ERR_ON: begin
        led_nxt     = '1;
        err_led_nxt = 1'b1;
      end
      default: begin
        led_nxt     = '0;
        err_led_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Led_out    <= '0;
      ErrLed_out <= 1'b0;
    end else begin
      Led_out    <= led_nxt;
      ErrLed_out <= err_led_nxt;
    end
  end

endmodule

// File: tb/tb_bargraph_led_driver.sv
// Self-checking bench for bargraph_led_driver: directed scenarios plus randomized traffic
// checked against a behavioural model built from the display rules.
module tb_bargraph_led_driver;

  localparam int DIV = 4;
  localparam int HT  = 2;
  localparam int BT  = 2;
  localparam int PW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    BGraph_in = '0;
  logic          Err_in = 1'b0;
  logic [PW-1:0] Bright_in = '0;
  logic [7:0]    Led_out;
  logic [7:0]    Peak_out;
  logic          ErrLed_out;

  int checks = 0;
  int errors = 0;

  bargraph_led_driver #(
    .PRESCALE_DIV(DIV),
    .PWM_BITS(PW),
    .HOLD_TICKS(HT),
    .BLINK_TICKS(BT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .BGraph_in(BGraph_in),
    .Err_in(Err_in),
    .Bright_in(Bright_in),
    .Led_out(Led_out),
    .Peak_out(Peak_out),
    .ErrLed_out(ErrLed_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] onehot(input int p);
    logic [7:0] one;
    one = 8'h01;
    return (p == 0) ? 8'h00 : (one << (p - 1));
  endfunction

  // Behavioural model: cycle count since reset drives tick and PWM phase,
  // blink phase derives from ticks spent in error.
  int         m_cyc;
  logic [7:0] m_bar;
  logic       m_err;
  bit         m_in_err;
  int         m_eticks;
  int         m_peak;
  int         m_hold;
  logic [7:0] m_led;
  logic [7:0] m_pk;
  logic       m_eled;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_bar = '0; m_err = 0; m_in_err = 0; m_eticks = 0;
      m_peak = 0; m_hold = 0; m_led = '0; m_pk = '0; m_eled = 0;
    end else begin
      bit tick;
      bit pwm_on;
      logic [7:0] old_pk;
      tick   = (m_cyc % DIV) == DIV - 1;
      pwm_on = (Bright_in == 3'd7) || ((m_cyc % 8) < int'(Bright_in));
      old_pk = m_pk;
      if (!m_in_err) begin
        if (m_err) begin
          m_in_err = 1;
          m_eticks = 0;
        end
      end else if (!m_err) begin
        m_in_err = 0;
      end else if (tick) begin
        m_eticks++;
      end
`ifdef PEAK_HOLD_EN
      if (m_in_err) begin
        m_peak = 0;
        m_hold = 0;
      end else begin
        int lvl;
        lvl = 0;
        for (int i = 0; i < 8; i++) if (m_bar[i]) lvl = i + 1;
        if (lvl >= m_peak) begin
          m_peak = lvl;
          m_hold = HT;
        end else if (tick) begin
          if (m_hold > 0) m_hold--;
          else if (m_peak > 0) m_peak--;
        end
      end
`endif
      m_pk = onehot(m_peak);
      if (!m_in_err) begin
        m_led  = pwm_on ? (m_bar | old_pk) : 8'h00;
        m_eled = 0;
      end else if (((m_eticks / BT) % 2) == 0) begin
        m_led  = 8'hFF;
        m_eled = 1;
      end else begin
        m_led  = 8'h00;
        m_eled = 0;
      end
      m_bar = BGraph_in;
      m_err = Err_in;
      m_cyc++;
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    BGraph_in = 8'h3F; Bright_in = 3'd7; Err_in = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (Led_out !== 8'h3F) begin
      errors++; $display("FAIL pre_reset_led got %h want %h", Led_out, 8'h3F);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (Led_out !== 8'h00 || Peak_out !== 8'h00 || ErrLed_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got led=%h pk=%h el=%b want 00 00 0", Led_out, Peak_out, ErrLed_out);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (Led_out !== 8'h00 || Peak_out !== 8'h00 || ErrLed_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_held got led=%h pk=%h el=%b want 00 00 0", Led_out, Peak_out, ErrLed_out);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    BGraph_in = 8'h00; Bright_in = 3'd7;
    do_reset();
    repeat (3) @(negedge clk);
    BGraph_in = 8'h0F;
    @(negedge clk);
    checks++;
    if (Led_out !== 8'h00) begin
      errors++; $display("FAIL latency_1clk got %h want %h", Led_out, 8'h00);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (Led_out !== 8'h0F) begin
        errors++; $display("FAIL latency_steady cyc %0d got %h want %h", k, Led_out, 8'h0F);
      end
      checks++;
`ifdef PEAK_HOLD_EN
      if (Peak_out !== 8'h08) begin
        errors++; $display("FAIL steady_peak cyc %0d got %h want %h", k, Peak_out, 8'h08);
      end
`else
      if (Peak_out !== 8'h00) begin
        errors++; $display("FAIL steady_peak cyc %0d got %h want %h", k, Peak_out, 8'h00);
      end
`endif
    end
  endtask

  task automatic test_pwm;
    int on_cnt;
    Bright_in = 3'd2; BGraph_in = 8'hFF;
    repeat (4) @(negedge clk);
    on_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (Led_out === 8'hFF) on_cnt++;
      checks++;
      if (Led_out !== 8'hFF && Led_out !== 8'h00) begin
        errors++; $display("FAIL pwm_level got %h want ff or 00", Led_out);
      end
      checks++;
      if (Led_out !== m_led) begin
        errors++; $display("FAIL pwm_model got %h want %h", Led_out, m_led);
      end
    end
    checks++;
    if (on_cnt != 4) begin
      errors++; $display("FAIL pwm_duty got %0d want %0d on cycles of 16", on_cnt, 4);
    end
    Bright_in = 3'd0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (Led_out !== 8'h00) begin
        errors++; $display("FAIL pwm_dark got %h want %h", Led_out, 8'h00);
      end
    end
  endtask

  task automatic test_peak_decay;
    logic [7:0] pk[60];
    logic [7:0] ld[60];
    logic [7:0] vals[$];
    int lens[$];
    Bright_in = 3'd7; BGraph_in = 8'hFF; Err_in = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    BGraph_in = 8'h01;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      pk[k] = Peak_out;
      ld[k] = Led_out;
      checks++;
      if (Peak_out !== m_pk || Led_out !== m_led) begin
        errors++;
        $display("FAIL decay_model cyc %0d got pk=%h led=%h want pk=%h led=%h", k, Peak_out, Led_out, m_pk, m_led);
      end
    end
`ifdef PEAK_HOLD_EN
    for (int k = 0; k < 60; k++) begin
      if (vals.size() == 0 || vals[vals.size()-1] !== pk[k]) begin
        vals.push_back(pk[k]);
        lens.push_back(1);
      end else begin
        lens[lens.size()-1]++;
      end
    end
    checks++;
    if (vals.size() != 8) begin
      errors++; $display("FAIL decay_steps got %0d want %0d", vals.size(), 8);
    end else begin
      for (int j = 0; j < 8; j++) begin
        logic [7:0] e;
        e = 8'h80;
        e = e >> j;
        checks++;
        if (vals[j] !== e) begin
          errors++; $display("FAIL decay_value step %0d got %h want %h", j, vals[j], e);
        end
      end
      checks++;
      if (lens[0] < 9 || lens[0] > 12) begin
        errors++; $display("FAIL decay_hold got %0d want 9..12 clk", lens[0]);
      end
      for (int j = 1; j < 7; j++) begin
        checks++;
        if (lens[j] != DIV) begin
          errors++; $display("FAIL decay_rate step %0d got %0d want %0d clk", j, lens[j], DIV);
        end
      end
    end
`else
    checks++;
    if (ld[0] !== 8'hFF || ld[1] !== 8'h01) begin
      errors++; $display("FAIL nopeak_led got %h %h want ff 01", ld[0], ld[1]);
    end
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (pk[k] !== 8'h00) begin
        errors++; $display("FAIL nopeak_peak cyc %0d got %h want 00", k, pk[k]);
      end
    end
`endif
  endtask

  task automatic test_error;
    int runs[$];
    int run;
    logic prev;
    bit found;
    Bright_in = 3'd7; BGraph_in = 8'h07; Err_in = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    Err_in = 1'b1;
    run = 0; prev = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      checks++;
      if (Led_out !== m_led || ErrLed_out !== m_eled || Peak_out !== m_pk) begin
        errors++;
        $display("FAIL err_model cyc %0d got led=%h el=%b pk=%h want led=%h el=%b pk=%h", k, Led_out, ErrLed_out, Peak_out, m_led, m_eled, m_pk);
      end
      if (k >= 1) begin
        checks++;
        if (Led_out !== (ErrLed_out ? 8'hFF : 8'h00)) begin
          errors++; $display("FAIL err_pair cyc %0d got led=%h el=%b", k, Led_out, ErrLed_out);
        end
        if (k > 1 && ErrLed_out !== prev) begin
          runs.push_back(run);
          run = 0;
        end
        run++;
        prev = ErrLed_out;
      end
    end
    checks++;
    if (runs.size() < 4) begin
      errors++; $display("FAIL err_blink_runs got %0d want >= 4", runs.size());
    end else begin
      for (int j = 1; j < runs.size(); j++) begin
        checks++;
        if (runs[j] != BT * DIV) begin
          errors++; $display("FAIL err_blink_period run %0d got %0d want %0d", j, runs[j], BT * DIV);
        end
      end
    end
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (ErrLed_out === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL err_wait_on got %b want 1 within 20 clk", ErrLed_out);
    end
    Err_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (Led_out !== 8'h07 || ErrLed_out !== 1'b0) begin
      errors++; $display("FAIL err_exit got led=%h el=%b want 07 0", Led_out, ErrLed_out);
    end
    checks++;
`ifdef PEAK_HOLD_EN
    if (Peak_out !== 8'h04) begin
      errors++; $display("FAIL err_exit_peak got %h want %h", Peak_out, 8'h04);
    end
`else
    if (Peak_out !== 8'h00) begin
      errors++; $display("FAIL err_exit_peak got %h want %h", Peak_out, 8'h00);
    end
`endif
    Err_in = 1'b1;
    repeat (5) @(negedge clk);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (ErrLed_out === 1'b1) found = 1;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!found || Led_out !== 8'h00 || ErrLed_out !== 1'b0 || Peak_out !== 8'h00) begin
      errors++;
      $display("FAIL err_reset_midblink got led=%h el=%b pk=%h seen_on=%b want 00 0 00 1", Led_out, ErrLed_out, Peak_out, found);
    end
    Err_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random;
    BGraph_in = 8'h00; Err_in = 1'b0; Bright_in = 3'd5;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      checks++;
      if (Led_out !== m_led || Peak_out !== m_pk || ErrLed_out !== m_eled) begin
        errors++;
        $display("FAIL random cyc %0d got led=%h pk=%h el=%b want led=%h pk=%h el=%b", k, Led_out, Peak_out, ErrLed_out, m_led, m_pk, m_eled);
      end
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) BGraph_in = 8'($urandom);
        else BGraph_in = 8'hFF >> $urandom_range(0, 8);
      end
      if ($urandom_range(0, 15) == 0) Bright_in = 3'($urandom);
      if (Err_in) begin
        if ($urandom_range(0, 19) == 0) Err_in = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        Err_in = 1'b1;
      end
    end
    Err_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_latency();
    test_pwm();
    test_peak_decay();
    test_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
